hazard_ctrl: RTL and testbench

Parametrised hazard controller for the 5-stage RV32I pipeline, successor to the original single-cycle hazard logic. Adds a configurable multi-cycle load-use bubble, a busy handshake for a multi-cycle mul/div unit in Execute, and explicit priority between stall and flush events. Sits beside the datapath and drives the pipeline-register enable and clear inputs plus the Execute operand forwarding muxes.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_ctrl_if.sv | 47 ++++
 rtl/hazard_fwd_sel.sv | 25 ++
 rtl/hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the RV32I hazard controller.
package hazard_pkg;

   localparam int unsigned REG_AW_DEF = 5;
   localparam int unsigned BUB_CNT_W  = 4;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_e;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD_WAIT = 2'd1,
      MD_BUSY   = 2'd2
   } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: datapath <-> hazard controller signal bundle.
// master = datapath side, slave = hazard controller side.
interface hazard_ctrl_if
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW = REG_AW_DEF,
   parameter int unsigned CNT_W  = 32
);
   logic              RegWriteM;
   logic              RegWriteW;
   logic              PCSrcE;
   logic [1:0]        ResultSrcE;
   logic              MdStartE;
   logic              MdDoneE;
   logic [REG_AW-1:0] Rs1D;
   logic [REG_AW-1:0] Rs2D;
   logic [REG_AW-1:0] Rs1E;
   logic [REG_AW-1:0] Rs2E;
   logic [REG_AW-1:0] RdE;
   logic [REG_AW-1:0] RdM;
   logic [REG_AW-1:0] RdW;
   logic [1:0]        ForwardAE;
   logic [1:0]        ForwardBE;
   logic              StallF;
   logic              StallD;
   logic              StallE;
   logic              FlushD;
   logic              FlushE;
   logic              FlushM;
   logic [CNT_W-1:0]  StallCycles;
   logic [CNT_W-1:0]  FlushCycles;

   modport master (
      output RegWriteM, RegWriteW, PCSrcE, ResultSrcE, MdStartE, MdDoneE,
             Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      input  ForwardAE, ForwardBE, StallF, StallD, StallE,
             FlushD, FlushE, FlushM, StallCycles, FlushCycles
   );

   modport slave (
      input  RegWriteM, RegWriteW, PCSrcE, ResultSrcE, MdStartE, MdDoneE,
             Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      output ForwardAE, ForwardBE, StallF, StallD, StallE,
             FlushD, FlushE, FlushM, StallCycles, FlushCycles
   );

endinterface

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: per-operand forwarding source select, M stage wins over W.
module hazard_fwd_sel
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW = REG_AW_DEF
) (
   input  logic [REG_AW-1:0] Rs,
   input  logic [REG_AW-1:0] RdM,
   input  logic [REG_AW-1:0] RdW,
   input  logic              RegWriteM,
   input  logic              RegWriteW,
   output fwd_sel_e          fwd
);

   // x0 is never forwarded; the nearest producer takes precedence.
   always_comb begin
      fwd = FWD_RF;
      if (RegWriteM && (Rs != '0) && (Rs == RdM)) begin
         fwd = FWD_M;
      end else if (RegWriteW && (Rs != '0) && (Rs == RdW)) begin
         fwd = FWD_W;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control for the 5-stage RV32I pipeline.
// Optional build macro HAZARD_PERF_EN enables the stall/flush cycle counters;
// without it both counter ports read zero.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW   = REG_AW_DEF,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned CNT_W    = 32
) (
   input logic         clk,
   input logic         rst,
   hazard_ctrl_if.slave hz
);

   hz_state_e              state_q, state_d;
   logic [BUB_CNT_W-1:0]   cnt_q, cnt_d;
   logic                   lu;
   logic                   stall_f, stall_d, stall_e;
   logic                   flush_d, flush_e, flush_m;
   fwd_sel_e               fwd_a, fwd_b;

   hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
      .Rs        (hz.Rs1E),
      .RdM       (hz.RdM),
      .RdW       (hz.RdW),
      .RegWriteM (hz.RegWriteM),
      .RegWriteW (hz.RegWriteW),
      .fwd       (fwd_a)
   );

   hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
      .Rs        (hz.Rs2E),
      .RdM       (hz.RdM),
      .RdW       (hz.RdW),
      .RegWriteM (hz.RegWriteM),
      .RegWriteW (hz.RegWriteW),
      .fwd       (fwd_b)
   );

   assign hz.ForwardAE = 2'(fwd_a);
   assign hz.ForwardBE = 2'(fwd_b);

   // Load in E whose destination is read by the instruction in D.
   assign lu = hz.ResultSrcE[0] && (hz.RdE != '0) &&
               ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));

   // State register and bubble counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state and stall/flush decode; mul/div > branch > load-use.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_m = 1'b0;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (hz.MdStartE && !hz.MdDoneE) begin
                  state_d = MD_BUSY;
                  stall_f = 1'b1;
                  stall_d = 1'b1;
                  stall_e = 1'b1;
                  flush_m = 1'b1;
               end else if (hz.PCSrcE) begin
                  flush_d = 1'b1;
                  flush_e = 1'b1;
               end else if (lu) begin
                  stall_f = 1'b1;
                  stall_d = 1'b1;
                  flush_e = 1'b1;
                  if (LOAD_LAT > 1) begin
                     state_d = LOAD_WAIT;
                     cnt_d   = BUB_CNT_W'(LOAD_LAT - 1);
                  end
               end
            end
            LOAD_WAIT: begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               flush_e = 1'b1;
               cnt_d   = cnt_q - BUB_CNT_W'(1);
               if (cnt_q == BUB_CNT_W'(1)) begin
                  state_d = IDLE;
               end
            end
            MD_BUSY: begin
               if (hz.MdDoneE) begin
                  state_d = IDLE;
               end else begin
                  stall_f = 1'b1;
                  stall_d = 1'b1;
                  stall_e = 1'b1;
                  flush_m = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign hz.StallF = stall_f;
   assign hz.StallD = stall_d;
   assign hz.StallE = stall_e;
   assign hz.FlushD = flush_d;
   assign hz.FlushE = flush_e;
   assign hz.FlushM = flush_m;

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   // Saturating counts of fetch-stall and decode-flush cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_f && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (flush_d && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

   assign hz.StallCycles = stall_cnt_q;
   assign hz.FlushCycles = flush_cnt_q;
`else
   assign hz.StallCycles = {CNT_W{1'b0}};
   assign hz.FlushCycles = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against a
// cycle-level behavioural model (LOAD_LAT=3, CNT_W=4).
module tb_hazard_ctrl;

   localparam int unsigned AW   = 5;
   localparam int unsigned LL   = 3;
   localparam int unsigned CW   = 4;
   localparam int          SAT  = 15;
`ifdef HAZARD_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // {StallF, StallD, StallE, FlushD, FlushE, FlushM}
   localparam logic [5:0] C_NONE = 6'b000000;
   localparam logic [5:0] C_LOAD = 6'b110010;
   localparam logic [5:0] C_MD   = 6'b111001;
   localparam logic [5:0] C_BR   = 6'b000110;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;

   // Model state: remaining load bubbles, mul/div in progress, counters.
   int   m_load_left = 0;
   bit   m_md_busy = 1'b0;
   int   m_sc = 0;
   int   m_fc = 0;

   hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) hz ();

   hazard_ctrl #(.REG_AW(AW), .LOAD_LAT(LL), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] model_fwd(input logic [AW-1:0] rs);
      if (hz.RegWriteM && rs != 0 && rs == hz.RdM) return 2'b10;
      if (hz.RegWriteW && rs != 0 && rs == hz.RdW) return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit model_lu();
      return hz.ResultSrcE[0] && hz.RdE != 0 &&
             (hz.Rs1D == hz.RdE || hz.Rs2D == hz.RdE);
   endfunction

   function automatic logic [5:0] model_ctl();
      if (rst) return C_NONE;
      if (m_md_busy) return hz.MdDoneE ? C_NONE : C_MD;
      if (m_load_left > 0) return C_LOAD;
      if (hz.MdStartE && !hz.MdDoneE) return C_MD;
      if (hz.PCSrcE) return C_BR;
      if (model_lu()) return C_LOAD;
      return C_NONE;
   endfunction

   function automatic logic [5:0] obs_ctl();
      return {hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE, hz.FlushM};
   endfunction

   // Advance the model by one cycle, then the clock.
   task automatic advance();
      logic [5:0] c;
      bit         lu;
      c  = model_ctl();
      lu = model_lu();
      if (rst) begin
         m_load_left = 0;
         m_md_busy   = 1'b0;
         m_sc        = 0;
         m_fc        = 0;
      end else begin
         if (m_md_busy) begin
            if (hz.MdDoneE) m_md_busy = 1'b0;
         end else if (m_load_left > 0) begin
            m_load_left--;
         end else if (hz.MdStartE && !hz.MdDoneE) begin
            m_md_busy = 1'b1;
         end else if (!hz.PCSrcE && lu) begin
            m_load_left = LL - 1;
         end
         if (PERF && c[5] && m_sc < SAT) m_sc++;
         if (PERF && c[2] && m_fc < SAT) m_fc++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      hz.RegWriteM = 0; hz.RegWriteW = 0; hz.PCSrcE = 0; hz.ResultSrcE = 0;
      hz.MdStartE = 0; hz.MdDoneE = 0;
      hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0;
      hz.RdE = 0; hz.RdM = 0; hz.RdW = 0;
   endtask

   task automatic do_reset();
      clear_in();
      rst = 1'b1;
      advance();
      advance();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      clear_in();
      rst = 1'b1;
      hz.ResultSrcE = 2'b01; hz.RdE = 5'd7; hz.Rs1D = 5'd7; hz.MdStartE = 1'b1;
      advance();
      @(negedge clk);
      checks++;
      if (obs_ctl() !== C_NONE) begin
         failures++;
         $display("FAIL reset_ctl got=%b exp=%b", obs_ctl(), C_NONE);
      end
      checks++;
      if (hz.StallCycles !== 4'd0 || hz.FlushCycles !== 4'd0) begin
         failures++;
         $display("FAIL reset_cnt got=%0d/%0d exp=0/0", hz.StallCycles, hz.FlushCycles);
      end
      advance();
      rst = 1'b0;
      clear_in();
      @(negedge clk);
      checks++;
      if (obs_ctl() !== C_NONE) begin
         failures++;
         $display("FAIL reset_idle got=%b exp=%b", obs_ctl(), C_NONE);
      end
      advance();
   endtask

   task automatic test_forwarding();
      clear_in();
      hz.Rs1E = 5'd5; hz.RdM = 5'd5; hz.RegWriteM = 1; hz.RdW = 5'd5; hz.RegWriteW = 1;
      #1;
      checks++;
      if (hz.ForwardAE !== 2'b10) begin
         failures++;
         $display("FAIL fwd_m_prio got=%b exp=10", hz.ForwardAE);
      end
      hz.RdM = 5'd0;
      #1;
      checks++;
      if (hz.ForwardAE !== 2'b01) begin
         failures++;
         $display("FAIL fwd_w got=%b exp=01", hz.ForwardAE);
      end
      hz.Rs2E = 5'd0; hz.RdM = 5'd0; hz.RegWriteM = 1;
      #1;
      checks++;
      if (hz.ForwardBE !== 2'b00) begin
         failures++;
         $display("FAIL fwd_x0 got=%b exp=00", hz.ForwardBE);
      end
      for (int i = 0; i < 40; i++) begin
         hz.Rs1E = 5'($urandom_range(0, 3));
         hz.Rs2E = 5'($urandom_range(0, 3));
         hz.RdM  = 5'($urandom_range(0, 3));
         hz.RdW  = 5'($urandom_range(0, 3));
         hz.RegWriteM = 1'($urandom_range(0, 1));
         hz.RegWriteW = 1'($urandom_range(0, 1));
         #1;
         checks++;
         if (hz.ForwardAE !== model_fwd(hz.Rs1E) || hz.ForwardBE !== model_fwd(hz.Rs2E)) begin
            failures++;
            $display("FAIL fwd_rand got=%b/%b exp=%b/%b", hz.ForwardAE, hz.ForwardBE,
                     model_fwd(hz.Rs1E), model_fwd(hz.Rs2E));
         end
      end
      clear_in();
   endtask

   task automatic test_load_use();
      int run = 0;
      do_reset();
      hz.ResultSrcE = 2'b01; hz.RdE = 5'd7; hz.Rs1D = 5'd7; hz.Rs2D = 5'd3;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (obs_ctl() !== ((c < 3) ? C_LOAD : C_NONE)) begin
            failures++;
            $display("FAIL load_use c%0d got=%b exp=%b", c, obs_ctl(),
                     (c < 3) ? C_LOAD : C_NONE);
         end
         if (hz.StallF === 1'b1) run++;
         advance();
         if (c == 0) hz.ResultSrcE = 2'b00;
      end
      checks++;
      if (run != 3) begin
         failures++;
         $display("FAIL load_use_len got=%0d exp=3", run);
      end
      checks++;
      if (hz.StallCycles !== (PERF ? 4'd3 : 4'd0)) begin
         failures++;
         $display("FAIL load_use_cnt got=%0d exp=%0d", hz.StallCycles, PERF ? 3 : 0);
      end
      clear_in();
      hz.ResultSrcE = 2'b01; hz.RdE = 5'd0; hz.Rs1D = 5'd0; hz.Rs2D = 5'd0;
      @(negedge clk);
      checks++;
      if (obs_ctl() !== C_NONE) begin
         failures++;
         $display("FAIL load_rd0 got=%b exp=%b", obs_ctl(), C_NONE);
      end
      advance();
      hz.RdE = 5'd7; hz.Rs2D = 5'd7; hz.PCSrcE = 1'b1;
      @(negedge clk);
      checks++;
      if (obs_ctl() !== C_BR) begin
         failures++;
         $display("FAIL load_branch got=%b exp=%b", obs_ctl(), C_BR);
      end
      advance();
      clear_in();
      @(negedge clk);
      checks++;
      if (obs_ctl() !== C_NONE) begin
         failures++;
         $display("FAIL load_branch_idle got=%b exp=%b", obs_ctl(), C_NONE);
      end
      advance();
   endtask

   task automatic test_muldiv();
      clear_in();
      hz.MdStartE = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++;
         if (obs_ctl() !== ((c < 4) ? C_MD : C_NONE)) begin
            failures++;
            $display("FAIL muldiv c%0d got=%b exp=%b", c, obs_ctl(),
                     (c < 4) ? C_MD : C_NONE);
         end
         advance();
         hz.MdStartE = 1'b0;
         hz.MdDoneE  = (c + 1 == 4);
      end
      hz.MdStartE = 1'b1; hz.MdDoneE = 1'b1;
      @(negedge clk);
      checks++;
      if (obs_ctl() !== C_NONE) begin
         failures++;
         $display("FAIL muldiv_1cyc got=%b exp=%b", obs_ctl(), C_NONE);
      end
      advance();
      clear_in();
      @(negedge clk);
      checks++;
      if (obs_ctl() !== C_NONE) begin
         failures++;
         $display("FAIL muldiv_1cyc_after got=%b exp=%b", obs_ctl(), C_NONE);
      end
      advance();
   endtask

   task automatic test_reset_mid();
      do_reset();
      hz.MdStartE = 1'b1;
      @(negedge clk);
      checks++;
      if (obs_ctl() !== C_MD) begin
         failures++;
         $display("FAIL rst_mid_start got=%b exp=%b", obs_ctl(), C_MD);
      end
      advance();
      hz.MdStartE = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (obs_ctl() !== C_NONE) begin
         failures++;
         $display("FAIL rst_mid_during got=%b exp=%b", obs_ctl(), C_NONE);
      end
      advance();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (obs_ctl() !== C_NONE || hz.StallCycles !== 4'd0 || hz.FlushCycles !== 4'd0) begin
         failures++;
         $display("FAIL rst_mid_after got=%b cnt=%0d/%0d exp=%b cnt=0/0", obs_ctl(),
                  hz.StallCycles, hz.FlushCycles, C_NONE);
      end
      advance();
   endtask

   task automatic test_saturation();
      int run = 0;
      do_reset();
      hz.ResultSrcE = 2'b01; hz.RdE = 5'd9; hz.Rs1D = 5'd9;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         checks++;
         if (obs_ctl() !== model_ctl()) begin
            failures++;
            $display("FAIL sat_ctl c%0d got=%b exp=%b", c, obs_ctl(), model_ctl());
         end
         if (hz.StallF === 1'b1) run++;
         advance();
      end
      checks++;
      if (run != 20) begin
         failures++;
         $display("FAIL sat_run got=%0d exp=20", run);
      end
      checks++;
      if (hz.StallCycles !== (PERF ? 4'hF : 4'h0)) begin
         failures++;
         $display("FAIL sat_cnt got=%0d exp=%0d", hz.StallCycles, PERF ? 15 : 0);
      end
      do_reset();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 59) == 0);
         hz.Rs1D = 5'($urandom_range(0, 7)); hz.Rs2D = 5'($urandom_range(0, 7));
         hz.Rs1E = 5'($urandom_range(0, 7)); hz.Rs2E = 5'($urandom_range(0, 7));
         hz.RdE  = 5'($urandom_range(0, 7)); hz.RdM  = 5'($urandom_range(0, 7));
         hz.RdW  = 5'($urandom_range(0, 7));
         hz.RegWriteM = 1'($urandom_range(0, 1));
         hz.RegWriteW = 1'($urandom_range(0, 1));
         if (m_md_busy) begin
            hz.MdStartE = 0; hz.PCSrcE = 0;
            hz.ResultSrcE = 2'($urandom_range(0, 3)) & 2'b10;
            hz.MdDoneE = ($urandom_range(0, 3) == 0);
         end else if (m_load_left > 0) begin
            hz.MdStartE = 0; hz.PCSrcE = 0; hz.ResultSrcE = 0; hz.MdDoneE = 0;
         end else begin
            hz.MdStartE = ($urandom_range(0, 5) == 0);
            hz.PCSrcE = !hz.MdStartE && ($urandom_range(0, 3) == 0);
            hz.ResultSrcE = 2'($urandom_range(0, 3));
            hz.MdDoneE = ($urandom_range(0, 2) == 0);
         end
         @(negedge clk);
         checks++;
         if (obs_ctl() !== model_ctl()) begin
            failures++;
            $display("FAIL rand_ctl c%0d got=%b exp=%b", c, obs_ctl(), model_ctl());
         end
         checks++;
         if (hz.ForwardAE !== model_fwd(hz.Rs1E) || hz.ForwardBE !== model_fwd(hz.Rs2E)) begin
            failures++;
            $display("FAIL rand_fwd c%0d got=%b/%b exp=%b/%b", c, hz.ForwardAE,
                     hz.ForwardBE, model_fwd(hz.Rs1E), model_fwd(hz.Rs2E));
         end
         checks++;
         if (hz.StallCycles !== 4'(m_sc) || hz.FlushCycles !== 4'(m_fc)) begin
            failures++;
            $display("FAIL rand_cnt c%0d got=%0d/%0d exp=%0d/%0d", c, hz.StallCycles,
                     hz.FlushCycles, m_sc, m_fc);
         end
         advance();
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      clear_in();
      test_reset();
      test_forwarding();
      test_load_use();
      test_muldiv();
      test_reset_mid();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
